// File: rtl/cim_bitserial_adder.sv
// Bit-serial A+B->D adder that sequences a CIM column array's read/write wordlines.
// Define CIM_CARRY_OUT_EN to also store the final carry into row d_base+nbits.
module cim_bitserial_adder #(
  parameter int ROWS   = 16,
  parameter int COLS   = 8,
  parameter int ROW_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROW_AW-1:0] a_base,
  input  logic [ROW_AW-1:0] b_base,
  input  logic [ROW_AW-1:0] d_base,
  input  logic [ROW_AW:0]   nbits,
  output logic [ROWS-1:0]   rwl,
  output logic [ROWS-1:0]   wwl,
  input  logic [COLS-1:0]   to_adder,
  output logic [COLS-1:0]   from_adder,
  output logic [COLS-1:0]   carry_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef CIM_CARRY_OUT_EN
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, OVF, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, DONE} state_t;
`endif

  state_t            state_reg;
  logic [ROW_AW-1:0] a_base_reg, b_base_reg, d_base_reg;
  logic [ROW_AW:0]   nbits_reg, idx_reg, idx_next;
  logic [COLS-1:0]   opa_reg, carry_reg;
  logic [COLS-1:0]   sum_next, carry_next;
  logic              nbits_ok, last_bit;

  function automatic logic [ROWS-1:0] row_sel(input logic [ROW_AW-1:0] addr);
    row_sel = '0;
    row_sel[addr] = 1'b1;
  endfunction

  assign nbits_ok = (nbits != '0) && (nbits <= (ROW_AW+1)'(ROWS));
  assign idx_next = idx_reg + (ROW_AW+1)'(1);
  assign last_bit = (idx_next >= nbits_reg);

  // Full adder per lane: to_adder carries the B bit while in RD_B.
  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_lane
      assign sum_next[gi]   = opa_reg[gi] ^ to_adder[gi] ^ carry_reg[gi];
      assign carry_next[gi] = (opa_reg[gi] & to_adder[gi]) |
                              (opa_reg[gi] & carry_reg[gi]) |
                              (to_adder[gi] & carry_reg[gi]);
    end
  endgenerate

  // Wordlines are registered and default low, so each is active for exactly one state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_base_reg <= '0;
      b_base_reg <= '0;
      d_base_reg <= '0;
      nbits_reg  <= '0;
      idx_reg    <= '0;
      opa_reg    <= '0;
      carry_reg  <= '0;
      rwl        <= '0;
      wwl        <= '0;
      from_adder <= '0;
      carry_out  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      rwl  <= '0;
      wwl  <= '0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (nbits_ok) begin
              a_base_reg <= a_base;
              b_base_reg <= b_base;
              d_base_reg <= d_base;
              nbits_reg  <= nbits;
              idx_reg    <= '0;
              carry_reg  <= '0;
              rwl        <= row_sel(a_base);
              busy       <= 1'b1;
              state_reg  <= RD_A;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RD_A: begin
          opa_reg   <= to_adder;
          rwl       <= row_sel(b_base_reg + idx_reg[ROW_AW-1:0]);
          state_reg <= RD_B;
        end
        RD_B: begin
          from_adder <= sum_next;
          carry_reg  <= carry_next;
          wwl        <= row_sel(d_base_reg + idx_reg[ROW_AW-1:0]);
          state_reg  <= WR;
        end
        WR: begin
          if (!last_bit) begin
            idx_reg   <= idx_next;
            rwl       <= row_sel(a_base_reg + idx_next[ROW_AW-1:0]);
            state_reg <= RD_A;
          end else begin
`ifdef CIM_CARRY_OUT_EN
            from_adder <= carry_reg;
            wwl        <= row_sel(d_base_reg + nbits_reg[ROW_AW-1:0]);
            state_reg  <= OVF;
`else
            state_reg  <= DONE;
`endif
          end
        end
`ifdef CIM_CARRY_OUT_EN
        OVF: begin
          state_reg <= DONE;
        end
`endif
        DONE: begin
          done      <= 1'b1;
          carry_out <= carry_reg;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cim_bitserial_adder.sv
// Bench for cim_bitserial_adder: a cell-array model answers the wordlines, and a
// per-bit arithmetic reference predicts array contents, carry and latency.
module tb_cim_bitserial_adder;
  localparam int ROWS = 16, COLS = 8, ROW_AW = 4;
`ifdef CIM_CARRY_OUT_EN
  localparam int OVF_EXTRA = 1;
`else
  localparam int OVF_EXTRA = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [ROW_AW-1:0] a_base = '0, b_base = '0, d_base = '0;
  logic [ROW_AW:0]   nbits = '0;
  logic [ROWS-1:0]   rwl, wwl;
  logic [COLS-1:0]   to_adder, from_adder, carry_out;
  logic busy, done, err;

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] mem_init [ROWS];
  logic [COLS-1:0] exp_mem [ROWS];
  logic [COLS-1:0] exp_carry;
  logic init_req = 1'b0;
  int checks = 0, errors = 0, viol = 0;
  int wr_rows[$];

  cim_bitserial_adder #(.ROWS(ROWS), .COLS(COLS), .ROW_AW(ROW_AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_base(a_base), .b_base(b_base),
    .d_base(d_base), .nbits(nbits), .rwl(rwl), .wwl(wwl), .to_adder(to_adder),
    .from_adder(from_adder), .carry_out(carry_out), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  // Cell array: wordline-selected writes on the clock edge, combinational reads.
  always @(posedge clk) begin
    if (init_req) mem <= mem_init;
    else for (int r = 0; r < ROWS; r++) if (wwl[r]) mem[r] <= from_adder;
  end
  always_comb begin
    to_adder = '0;
    for (int r = 0; r < ROWS; r++) if (rwl[r]) to_adder = to_adder | mem[r];
  end

  always @(negedge clk) if (rst_n) begin
    if (!$onehot0(rwl) || !$onehot0(wwl) || (rwl != '0 && wwl != '0)) begin
      viol++;
      $display("protocol violation: rwl=%h wwl=%h", rwl, wwl);
    end
    for (int r = 0; r < ROWS; r++) if (wwl[r]) wr_rows.push_back(r);
  end

  task automatic load_mem(input bit rnd);
    if (rnd) for (int r = 0; r < ROWS; r++) mem_init[r] = COLS'($urandom);
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
  endtask

  // Reference: lane-wise binary addition, one bit position at a time, on a copy of the array.
  task automatic model_op(input int a, input int b, input int d, input int n);
    int s;
    for (int r = 0; r < ROWS; r++) exp_mem[r] = mem[r];
    exp_carry = '0;
    for (int i = 0; i < n; i++)
      for (int l = 0; l < COLS; l++) begin
        s = int'(exp_mem[(a+i)%ROWS][l]) + int'(exp_mem[(b+i)%ROWS][l]) + int'(exp_carry[l]);
        exp_mem[(d+i)%ROWS][l] = s[0];
        exp_carry[l] = s[1];
      end
    if (OVF_EXTRA != 0) exp_mem[(d+n)%ROWS] = exp_carry;
  endtask

  task automatic do_op(input int a, input int b, input int d, input int n, output int lat);
    a_base = ROW_AW'(a); b_base = ROW_AW'(b); d_base = ROW_AW'(d);
    nbits = (ROW_AW+1)'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
    $display("op a=%0d b=%0d d=%0d n=%0d latency=%0d carry_out=%h", a, b, d, n, lat, carry_out);
  endtask

  task automatic test_reset;
    checks++;
    if ({rwl, wwl, from_adder, carry_out, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rwl=%h wwl=%h fa=%h co=%h busy=%b done=%b err=%b, required all 0",
               rwl, wwl, from_adder, carry_out, busy, done, err);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_add_basic;
    int lat;
    for (int r = 0; r < ROWS; r++) mem_init[r] = COLS'($urandom);
    mem_init[0] = '1; mem_init[1] = '0; mem_init[2] = '1; mem_init[3] = '0;   // A = 5
    mem_init[4] = '1; mem_init[5] = '1; mem_init[6] = '0; mem_init[7] = '0;   // B = 3
    load_mem(1'b0);
    model_op(0, 4, 8, 4);
    do_op(0, 4, 8, 4, lat);
    checks++;
    if (lat !== 13 + OVF_EXTRA) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, 13 + OVF_EXTRA); end
    checks++;
    if ({mem[11], mem[10], mem[9], mem[8]} !== {8'hFF, 8'h00, 8'h00, 8'h00}) begin
      errors++; $display("FAIL basic_sum8: rows11..8=%h %h %h %h required ff 00 00 00", mem[11], mem[10], mem[9], mem[8]);
    end
    checks++;
    if (carry_out !== 8'h00) begin errors++; $display("FAIL basic_carry: got %h required 00", carry_out); end
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (mem[r] !== exp_mem[r]) begin errors++; $display("FAIL basic_row%0d: got %h required %h", r, mem[r], exp_mem[r]); end
    end
  endtask

  task automatic test_carry;
    int lat;
    for (int r = 0; r < ROWS; r++) mem_init[r] = '0;
    for (int r = 0; r < 4; r++) mem_init[r] = '1;                           // A = F
    mem_init[4] = '1;                                                         // B = 1
    mem_init[12] = 8'h5A;
    load_mem(1'b0);
    do_op(0, 4, 8, 4, lat);
    checks++;
    if (lat !== 13 + OVF_EXTRA) begin errors++; $display("FAIL carry_latency: got %0d required %0d", lat, 13 + OVF_EXTRA); end
    checks++;
    if ({mem[11], mem[10], mem[9], mem[8]} !== 32'h0) begin errors++; $display("FAIL carry_sum: rows11..8=%h%h%h%h required 0", mem[11], mem[10], mem[9], mem[8]); end
    checks++;
    if (carry_out !== 8'hFF) begin errors++; $display("FAIL carry_out: got %h required ff", carry_out); end
    checks++;
    if (mem[12] !== ((OVF_EXTRA != 0) ? 8'hFF : 8'h5A)) begin
      errors++; $display("FAIL carry_row12: got %h required %h", mem[12], (OVF_EXTRA != 0) ? 8'hFF : 8'h5A);
    end
  endtask

  task automatic test_err;
    int bad [2] = '{0, 17};
    for (int k = 0; k < 2; k++) begin
      nbits = (ROW_AW+1)'(bad[k]); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      $display("reject n=%0d err=%b busy=%b", bad[k], err, busy);
      checks++;
      if ({err, busy, rwl, wwl} !== {1'b1, 1'b0, 32'h0}) begin
        errors++; $display("FAIL err_pulse_n%0d: err=%b busy=%b rwl=%h wwl=%h required 1 0 0 0", bad[k], err, busy, rwl, wwl);
      end
      @(posedge clk); #1;
      checks++;
      if ({err, busy} !== 2'b00) begin errors++; $display("FAIL err_one_cycle_n%0d: err=%b busy=%b required 0 0", bad[k], err, busy); end
    end
  endtask

  task automatic test_wrap;
    int lat, base;
    int exp_rows [5] = '{14, 15, 0, 1, 2};
    load_mem(1'b1);
    model_op(2, 6, 14, 4);
    base = wr_rows.size();
    do_op(2, 6, 14, 4, lat);
    checks++;
    if (wr_rows.size() - base !== 4 + OVF_EXTRA) begin
      errors++; $display("FAIL wrap_write_count: got %0d required %0d", wr_rows.size() - base, 4 + OVF_EXTRA);
    end else begin
      for (int k = 0; k < 4 + OVF_EXTRA; k++) begin
        checks++;
        if (wr_rows[base+k] !== exp_rows[k]) begin errors++; $display("FAIL wrap_row_order%0d: got %0d required %0d", k, wr_rows[base+k], exp_rows[k]); end
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (mem[r] !== exp_mem[r]) begin errors++; $display("FAIL wrap_row%0d: got %h required %h", r, mem[r], exp_mem[r]); end
    end
  endtask

  task automatic test_ignore_start;
    int lat = -1;
    bit saw_err = 1'b0;
    load_mem(1'b1);
    model_op(1, 5, 9, 3);
    a_base = 4'd1; b_base = 4'd5; d_base = 4'd9; nbits = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin start = 1'b1; nbits = '0; a_base = 4'd7; end
      if (c == 6) start = 1'b0;
      if (err) saw_err = 1'b1;
      if (done) begin lat = c; break; end
    end
    $display("op with start held mid-run: latency=%0d err_seen=%b", lat, saw_err);
    checks++;
    if (lat !== 10 + OVF_EXTRA || saw_err !== 1'b0) begin
      errors++; $display("FAIL ignore_start: latency=%0d err_seen=%b required %0d 0", lat, saw_err, 10 + OVF_EXTRA);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_idle: busy=%b required 0", busy); end
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (mem[r] !== exp_mem[r]) begin errors++; $display("FAIL ignore_row%0d: got %h required %h", r, mem[r], exp_mem[r]); end
    end
  endtask

  task automatic test_random;
    int a, b, d, n, lat;
    for (int t = 0; t < 10; t++) begin
      load_mem(1'b1);
      a = $urandom_range(0, ROWS-1); b = $urandom_range(0, ROWS-1);
      d = (t % 3 == 0) ? a : $urandom_range(0, ROWS-1);
      n = (t == 0) ? ROWS : ((t == 1) ? 1 : $urandom_range(1, ROWS));
      model_op(a, b, d, n);
      do_op(a, b, d, n, lat);
      checks++;
      if (lat !== 3*n + 1 + OVF_EXTRA) begin errors++; $display("FAIL rand%0d_latency: got %0d required %0d", t, lat, 3*n + 1 + OVF_EXTRA); end
      checks++;
      if (carry_out !== exp_carry) begin errors++; $display("FAIL rand%0d_carry: got %h required %h", t, carry_out, exp_carry); end
      for (int r = 0; r < ROWS; r++) begin
        checks++;
        if (mem[r] !== exp_mem[r]) begin errors++; $display("FAIL rand%0d_row%0d: got %h required %h", t, r, mem[r], exp_mem[r]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0, lat;
    logic [COLS-1:0] row9_before;
    load_mem(1'b1);
    model_op(0, 4, 8, 4);
    row9_before = mem[9];
    a_base = 4'd0; b_base = 4'd4; d_base = 4'd8; nbits = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40 && seen < 2; c++) begin
      @(posedge clk); #1;
      if (wwl != '0) seen++;
    end
    checks++;
    if (seen !== 2) begin errors++; $display("FAIL midreset_second_wr: saw %0d writes required 2", seen); end
    rst_n = 1'b0;
    #1;
    $display("reset during second WR: wwl=%h rwl=%h busy=%b", wwl, rwl, busy);
    checks++;
    if ({wwl, rwl, busy} !== '0) begin errors++; $display("FAIL midreset_drop: wwl=%h rwl=%h busy=%b required 0", wwl, rwl, busy); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem[8] !== exp_mem[8] || mem[9] !== row9_before) begin
      errors++; $display("FAIL midreset_rows: row8=%h row9=%h required %h %h", mem[8], mem[9], exp_mem[8], row9_before);
    end
    load_mem(1'b1);
    model_op(3, 10, 5, 6);
    do_op(3, 10, 5, 6, lat);
    checks++;
    if (lat !== 19 + OVF_EXTRA || carry_out !== exp_carry) begin
      errors++; $display("FAIL postreset_op: latency=%0d carry=%h required %0d %h", lat, carry_out, 19 + OVF_EXTRA, exp_carry);
    end
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (mem[r] !== exp_mem[r]) begin errors++; $display("FAIL postreset_row%0d: got %h required %h", r, mem[r], exp_mem[r]); end
    end
  endtask

  task automatic test_protocol;
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL wordline_protocol: %0d violating cycles, required 0", viol); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_add_basic;
    test_carry;
    test_err;
    test_wrap;
    test_ignore_start;
    test_random;
    test_reset_mid;
    test_protocol;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cim_bitserial_adder.md
CIM_BITSERIAL_ADDER -- requirements
Module: cim_bitserial_adder

Interface
REQ-001 SHALL have parameter ROWS, default 16: rows in the CIM array column (power of 2, at least 4).
REQ-002 SHALL have parameter COLS, default 8: independent bit-serial lanes, one per array column.
REQ-003 SHALL have parameter ROW_AW, default 4: row address width, equal to log2(ROWS).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: request one A+B->D operation; sampled only in IDLE.
REQ-007 SHALL have ports a_base, b_base and d_base, each input, ROW_AW bits: LSB row of operand A, operand B and destination D.
REQ-008 SHALL have port nbits, input, ROW_AW+1 bits: operand bit count, legal range 1..ROWS.
REQ-009 SHALL have port rwl, output, ROWS bits: one-hot read wordline selecting the row that drives to_adder.
REQ-010 SHALL have port wwl, output, ROWS bits: one-hot write wordline; the selected row stores from_adder.
REQ-011 SHALL have port to_adder, input, COLS bits: per-column stored bit of the row selected by rwl.
REQ-012 SHALL have port from_adder, output, COLS bits: per-column sum bit written to the cells.
REQ-013 SHALL have port carry_out, output, COLS bits: per-lane carry after the last bit.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse on completion.
REQ-016 SHALL have port err, output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-017 SHALL implement states IDLE, RD_A, RD_B, WR, (OVF), DONE.
REQ-018 In IDLE, start=1 with nbits in 1..ROWS SHALL latch the bases and nbits, set bit index i=0, clear the carry register, and go to RD_A.
REQ-019 In IDLE, start=1 with nbits=0 or nbits>ROWS SHALL pulse err the next cycle and remain in IDLE.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 RD_A SHALL assert rwl[(a_base+i) mod ROWS] and capture to_adder into register opa at the cycle end.
REQ-022 RD_B SHALL assert rwl[(b_base+i) mod ROWS] and, at the cycle end, register:
  - from_adder <= opa ^ to_adder ^ carry;
  - carry <= majority(opa, to_adder, carry), per lane.
REQ-023 WR SHALL assert wwl[(d_base+i) mod ROWS] for exactly one cycle, with from_adder held stable throughout.
REQ-024 WR SHALL then go to RD_A with i+1 if i<nbits-1; otherwise to OVF (macro defined) or DONE.
REQ-025 DONE SHALL pulse done for one cycle, copy carry into carry_out, and return to IDLE.
REQ-026 Latency from the start-accept edge to done high SHALL be 3*nbits+1 cycles (+1 with the macro); each bit takes 3 cycles.
REQ-027 rwl and wwl SHALL never be nonzero in the same cycle, and each SHALL have at most one bit set.
REQ-028 Row addresses SHALL wrap modulo ROWS; overlapping D with A or B is legal, since row i is read before it is written.
REQ-029 from_adder and carry_out SHALL hold their values until next updated.

Reset
REQ-030 rst_n low SHALL immediately force the following, independent of clk:
  - state IDLE;
  - rwl, wwl, from_adder, carry_out, carry, opa all 0;
  - busy, done, err all 0.
REQ-031 Reset mid-operation SHALL drop wwl/rwl asynchronously; destination contents already written are not restored.

Configuration
REQ-032 Macro CIM_CARRY_OUT_EN SHALL, when defined, add state OVF after the final WR.
  - OVF asserts wwl[(d_base+nbits) mod ROWS] with from_adder = final carry, for one cycle.
REQ-033 Without CIM_CARRY_OUT_EN, OVF SHALL not exist, the final carry SHALL be visible only on carry_out, and latency SHALL be 3*nbits+1.

Verification
REQ-034 Behavioural cell-array model, lanes A=5,B=3, a_base=0,b_base=4,d_base=8,nbits=4 -> rows 8..11 = 0,0,0,1 (8); done at cycle 13; carry_out lane=0.
REQ-035 A=4'hF,B=4'h1, nbits=4, macro defined -> rows d..d+3=0, row d+4=1, done at cycle 14; macro undefined -> carry_out=1, row d+4 untouched.
REQ-036 start with nbits=0, then nbits=17 (ROWS=16) -> err pulse each time, busy stays 0, rwl/wwl stay 0.
REQ-037 d_base=14, nbits=4 -> wwl hits rows 14,15,0,1 in order; assertion checks one-hot rwl/wwl, never both active, start ignored while busy.
REQ-038 rst_n low during the second WR -> wwl=0 in the same timestep, busy=0; a fresh start afterwards completes correctly.
